// File: rtl/muldiv_alu_control.sv
// muldiv_alu_control: EX-stage ALU control decode plus an iterative
// MULTU/DIVU engine that owns the HI/LO registers.
//
// Optional feature macro: SIGNED_MULDIV_EN (adds signed MULT/DIV).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   start        EX-stage instruction valid
//   ALUOp        instruction class from main control
//   ALUFunction  instruction funct field
//   ReadData1    rs operand (multiplicand / dividend)
//   ReadData2    rt operand (multiplier / divisor)
//   ALUOperation ALU op code (combinational)
//   Stall        hold PC/IF/ID/EX while high
//   Done         one-cycle pulse: HI/LO just updated
//   Hi, Lo       HI/LO registers
module muldiv_alu_control #(
   parameter int DATA_WIDTH  = 32,
   parameter int ALUOP_WIDTH = 3,
   parameter int FUNCT_WIDTH = 6,
   parameter int OP_WIDTH    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ALUOP_WIDTH-1:0] ALUOp,
   input  logic [FUNCT_WIDTH-1:0] ALUFunction,
   input  logic [DATA_WIDTH-1:0]  ReadData1,
   input  logic [DATA_WIDTH-1:0]  ReadData2,
   output logic [OP_WIDTH-1:0]    ALUOperation,
   output logic                   Stall,
   output logic                   Done,
   output logic [DATA_WIDTH-1:0]  Hi,
   output logic [DATA_WIDTH-1:0]  Lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [ALUOP_WIDTH-1:0] AO_RTYPE = ALUOP_WIDTH'(3'b111);
   localparam logic [ALUOP_WIDTH-1:0] AO_LUI   = ALUOP_WIDTH'(3'b011);
   localparam logic [ALUOP_WIDTH-1:0] AO_ADDI  = ALUOP_WIDTH'(3'b100);
   localparam logic [ALUOP_WIDTH-1:0] AO_ORI   = ALUOP_WIDTH'(3'b101);

   localparam logic [FUNCT_WIDTH-1:0] F_AND   = FUNCT_WIDTH'(6'b100100);
   localparam logic [FUNCT_WIDTH-1:0] F_OR    = FUNCT_WIDTH'(6'b100101);
   localparam logic [FUNCT_WIDTH-1:0] F_NOR   = FUNCT_WIDTH'(6'b100111);
   localparam logic [FUNCT_WIDTH-1:0] F_ADD   = FUNCT_WIDTH'(6'b100000);
   localparam logic [FUNCT_WIDTH-1:0] F_SUB   = FUNCT_WIDTH'(6'b100010);
   localparam logic [FUNCT_WIDTH-1:0] F_SLL   = FUNCT_WIDTH'(6'b000000);
   localparam logic [FUNCT_WIDTH-1:0] F_SRL   = FUNCT_WIDTH'(6'b000010);
   localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = FUNCT_WIDTH'(6'b010000);
   localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = FUNCT_WIDTH'(6'b010010);
   localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(6'b011001);
   localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'(6'b011011);
`ifdef SIGNED_MULDIV_EN
   localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(6'b011000);
   localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'(6'b011010);
`endif

   localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4'b0000);
   localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4'b0001);
   localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(4'b0010);
   localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4'b0011);
   localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4'b0100);
   localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(4'b0101);
   localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(4'b0110);
   localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(4'b0111);
   localparam logic [OP_WIDTH-1:0] OP_MD   = OP_WIDTH'(4'b1000);
   localparam logic [OP_WIDTH-1:0] OP_BAD  = OP_WIDTH'(4'b1001);
   localparam logic [OP_WIDTH-1:0] OP_MFHI = OP_WIDTH'(4'b1010);
   localparam logic [OP_WIDTH-1:0] OP_MFLO = OP_WIDTH'(4'b1011);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    acc_a;
   logic [W-1:0]    acc_b;
   logic [W-1:0]    opnd;

   logic            rtype;
   logic            go_mul;
   logic            go_div;
   logic            accept;
   logic            last;
   logic [W-1:0]    mag1;
   logic [W-1:0]    mag2;

   logic [W:0]      sum;
   logic [W-1:0]    mul_hi;
   logic [W-1:0]    mul_lo;
   logic [W:0]      shl;
   logic [W:0]      diff;
   logic [W-1:0]    div_rem;
   logic [W-1:0]    div_quo;
   logic [2*W-1:0]  fin_prod;
   logic [W-1:0]    fin_quo;
   logic [W-1:0]    fin_rem;

`ifdef SIGNED_MULDIV_EN
   logic            sgn_op;
   logic            neg1;
   logic            neg2;
   logic            neg_q;
   logic            neg_r;
`endif

   // ---------------- decode ----------------
   assign rtype = (ALUOp == AO_RTYPE);

   always_comb begin
      ALUOperation = OP_BAD;
      unique case (1'b1)
         rtype: begin
            case (ALUFunction)
               F_AND:   ALUOperation = OP_AND;
               F_OR:    ALUOperation = OP_OR;
               F_NOR:   ALUOperation = OP_NOR;
               F_ADD:   ALUOperation = OP_ADD;
               F_SUB:   ALUOperation = OP_SUB;
               F_SLL:   ALUOperation = OP_SLL;
               F_SRL:   ALUOperation = OP_SRL;
               F_MFHI:  ALUOperation = OP_MFHI;
               F_MFLO:  ALUOperation = OP_MFLO;
               F_MULTU: ALUOperation = OP_MD;
               F_DIVU:  ALUOperation = OP_MD;
`ifdef SIGNED_MULDIV_EN
               F_MULT:  ALUOperation = OP_MD;
               F_DIV:   ALUOperation = OP_MD;
`endif
               default: ALUOperation = OP_BAD;
            endcase
         end
         (ALUOp == AO_LUI):  ALUOperation = OP_LUI;
         (ALUOp == AO_ADDI): ALUOperation = OP_ADD;
         (ALUOp == AO_ORI):  ALUOperation = OP_OR;
         default:            ALUOperation = OP_BAD;
      endcase
   end

   // ---------------- engine launch ----------------
`ifdef SIGNED_MULDIV_EN
   assign go_mul = rtype &&
      (ALUFunction == F_MULTU || ALUFunction == F_MULT);
   assign go_div = rtype &&
      (ALUFunction == F_DIVU || ALUFunction == F_DIV);
   assign sgn_op = rtype &&
      (ALUFunction == F_MULT || ALUFunction == F_DIV);
   assign neg1 = sgn_op & ReadData1[W-1];
   assign neg2 = sgn_op & ReadData2[W-1];
   // The engine is unsigned; signed ops run on magnitudes.
   assign mag1 = neg1 ? -ReadData1 : ReadData1;
   assign mag2 = neg2 ? -ReadData2 : ReadData2;
`else
   assign go_mul = rtype && (ALUFunction == F_MULTU);
   assign go_div = rtype && (ALUFunction == F_DIVU);
   assign mag1   = ReadData1;
   assign mag2   = ReadData2;
`endif

   assign accept = (state == IDLE) && start && (go_mul || go_div);

   // MUL/DIV stall covers the MFHI/MFLO interlock as well.
   assign Stall = (state == MUL) || (state == DIV) || accept;

   assign last = (cnt == CW'(W - 1));

   // ---------------- one iteration ----------------
   // Shift-add: acc_a = running high half, acc_b = multiplier
   // shifting out while product low bits shift in.
   assign sum    = {1'b0, acc_a} + (acc_b[0] ? {1'b0, opnd} : '0);
   assign mul_hi = sum[W:1];
   assign mul_lo = {sum[0], acc_b[W-1:1]};

   // Restoring divide: acc_a = partial remainder, acc_b =
   // dividend shifting out while quotient bits shift in.
   assign shl  = {acc_a, acc_b[W-1]};
   assign diff = shl - {1'b0, opnd};

   always_comb begin
      if (!diff[W]) begin
         div_rem = diff[W-1:0];
         div_quo = {acc_b[W-2:0], 1'b1};
      end else begin
         div_rem = shl[W-1:0];
         div_quo = {acc_b[W-2:0], 1'b0};
      end
   end

`ifdef SIGNED_MULDIV_EN
   assign fin_prod = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
   assign fin_quo  = neg_q ? -div_quo : div_quo;
   assign fin_rem  = neg_r ? -div_rem : div_rem;
`else
   assign fin_prod = {mul_hi, mul_lo};
   assign fin_quo  = div_quo;
   assign fin_rem  = div_rem;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         acc_a <= '0;
         acc_b <= '0;
         opnd  <= '0;
         Hi    <= '0;
         Lo    <= '0;
         Done  <= 1'b0;
`ifdef SIGNED_MULDIV_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else begin
         Done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  cnt   <= '0;
                  acc_a <= '0;
`ifdef SIGNED_MULDIV_EN
                  neg_q <= neg1 ^ neg2;
                  neg_r <= neg1;
`endif
                  if (go_mul) begin
                     acc_b <= mag2;
                     opnd  <= mag1;
                     state <= MUL;
                  end else if (ReadData2 == '0) begin
                     Hi    <= ReadData1;
                     Lo    <= '1;
                     Done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     acc_b <= mag1;
                     opnd  <= mag2;
                     state <= DIV;
                  end
               end
            end
            MUL: begin
               acc_a <= mul_hi;
               acc_b <= mul_lo;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  {Hi, Lo} <= fin_prod;
                  Done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DIV: begin
               acc_a <= div_rem;
               acc_b <= div_quo;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  Hi    <= fin_rem;
                  Lo    <= fin_quo;
                  Done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               // The finished instruction is still in EX here.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_alu_control.sv
// tb_muldiv_alu_control: directed bench with an expected-result
// queue for the mul/div engine of muldiv_alu_control.
module tb_muldiv_alu_control;

   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
`ifdef SIGNED_MULDIV_EN
   localparam logic [3:0] SOP = 4'b1000;
`else
   localparam logic [3:0] SOP = 4'b1001;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  ALUOp;
   logic [5:0]  ALUFunction;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [3:0]  ALUOperation;
   logic        Stall;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb[$];

   // {ALUOp, funct, expected op}
   localparam int ND = 17;
   localparam logic [12:0] DEC [ND] = '{
      {3'b111, 6'b100100, 4'b0000},
      {3'b111, 6'b100101, 4'b0001},
      {3'b111, 6'b100111, 4'b0010},
      {3'b111, 6'b100000, 4'b0011},
      {3'b111, 6'b100010, 4'b0100},
      {3'b111, 6'b000000, 4'b0101},
      {3'b111, 6'b000010, 4'b0110},
      {3'b111, 6'b010000, 4'b1010},
      {3'b111, 6'b010010, 4'b1011},
      {3'b111, 6'b011001, 4'b1000},
      {3'b111, 6'b011011, 4'b1000},
      {3'b011, 6'b101010, 4'b0111},
      {3'b100, 6'b000111, 4'b0011},
      {3'b101, 6'b110000, 4'b0001},
      {3'b111, 6'b111111, 4'b1001},
      {3'b000, 6'b100000, 4'b1001},
      {3'b111, 6'b011000, SOP}
   };

   muldiv_alu_control dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .ALUOp        (ALUOp),
      .ALUFunction  (ALUFunction),
      .ReadData1    (ReadData1),
      .ReadData2    (ReadData2),
      .ALUOperation (ALUOperation),
      .Stall        (Stall),
      .Done         (Done),
      .Hi           (Hi),
      .Lo           (Lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [63:0] model(input logic [5:0] f,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      logic signed [31:0] qx;
      logic signed [31:0] qy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      qx = x;
      qy = y;
      if (f == F_MULTU) return {32'd0, x} * {32'd0, y};
      if (f == F_MULT) return sx * sy;
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (f == F_DIV) return {32'(qx % qy), 32'(qx / qy)};
      return {x % y, x / y};
   endfunction

   // Issue one mul/div in the current cycle and wait for Done.
   task automatic run_op(input string tag,
                         input logic [5:0] f,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input bit hold,
                         input logic [5:0] follow,
                         input bit keep,
                         input int exp_cyc);
      int n;
      int cyc;
      logic [63:0] e;
      sb.push_back(model(f, x, y));
      ALUOp = 3'b111;
      ALUFunction = f;
      ReadData1 = x;
      ReadData2 = y;
      start = 1'b1;
      n = 0;
      cyc = 0;
      #1;
      while (!Done && cyc < 100) begin
         if (Stall) n++;
         step();
         cyc++;
         ALUFunction = follow;
         start = hold;
         ReadData1 = $urandom;
         ReadData2 = $urandom;
         #1;
      end
      if (!keep) start = 1'b0;
      check({tag, " done"}, 64'(Done), 64'd1);
      check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
      check({tag, " stalls"}, 64'(n), 64'(exp_cyc));
      check({tag, " done stall"}, 64'(Stall), 64'd0);
      if (sb.size() == 0) begin
         check({tag, " queue"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " hi"}, 64'(Hi), 64'(e[63:32]));
         check({tag, " lo"}, 64'(Lo), 64'(e[31:0]));
      end
   endtask

   initial begin
      bit seen;
      reset = 1'b1;
      start = 1'b0;
      ALUOp = 3'b000;
      ALUFunction = 6'b0;
      ReadData1 = 32'd0;
      ReadData2 = 32'd0;
      repeat (2) step();
      check("rst hi", 64'(Hi), 64'd0);
      check("rst lo", 64'(Lo), 64'd0);
      check("rst done", 64'(Done), 64'd0);
      reset = 1'b0;
      #1;
      check("rst stall", 64'(Stall), 64'd0);

      for (int i = 0; i < ND; i++) begin
         logic [12:0] d;
         d = DEC[i];
         ALUOp = d[12:10];
         ALUFunction = d[9:4];
         #1;
         check($sformatf("decode %0d", i),
               64'(ALUOperation), 64'(d[3:0]));
      end
`ifdef SIGNED_MULDIV_EN
      ALUOp = 3'b111;
      ALUFunction = F_DIV;
      #1;
      check("decode div", 64'(ALUOperation), 64'd8);
`endif
      step();

      run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'd2,
             1'b1, F_MULTU, 1'b0, 33);
      check("multu hi val", 64'(Hi), 64'h1);
      check("multu lo val", 64'(Lo), 64'hFFFF_FFFE);
      step();
      check("done pulse", 64'(Done), 64'd0);

      run_op("divu 100/7", F_DIVU, 32'd100, 32'd7,
             1'b0, F_DIVU, 1'b0, 33);
      check("divu q", 64'(Lo), 64'd14);
      check("divu r", 64'(Hi), 64'd2);
      step();
      run_op("divu by0", F_DIVU, 32'h1234, 32'd0,
             1'b0, F_DIVU, 1'b0, 1);
      check("div0 hi", 64'(Hi), 64'h1234);
      step();

      ALUOp = 3'b111;
      ALUFunction = F_MULTU;
      ReadData1 = 32'd3;
      ReadData2 = 32'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      check("mid stall", 64'(Stall), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("abort hi", 64'(Hi), 64'd0);
      check("abort lo", 64'(Lo), 64'd0);
      check("abort stall", 64'(Stall), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (Done) seen = 1'b1;
         step();
      end
      check("abort no done", 64'(seen), 64'd0);
      run_op("multu 3x5", F_MULTU, 32'd3, 32'd5,
             1'b0, F_MULTU, 1'b0, 33);
      step();

      run_op("mfhi lock", F_DIVU, 32'd1000, 32'd9,
             1'b1, F_MFHI, 1'b0, 33);
      check("mfhi op", 64'(ALUOperation), 64'hA);
      step();

      run_op("b2b first", F_MULTU, 32'h0001_0000, 32'h0001_0001,
             1'b1, F_MULTU, 1'b1, 33);
      step();
      check("b2b accept", 64'(Stall), 64'd1);
      run_op("b2b second", F_MULTU, 32'd123456789, 32'd987654321,
             1'b0, F_MULTU, 1'b0, 33);
      step();

      for (int i = 0; i < 4; i++) begin
         logic [31:0] x;
         logic [31:0] y;
         x = $urandom;
         y = (i == 3) ? 32'd1 : $urandom_range(1, 70000);
         run_op($sformatf("rnd %0d", i),
                (i % 2 == 0) ? F_MULTU : F_DIVU, x, y,
                1'b0, F_DIVU, 1'b0, 33);
         step();
      end

`ifdef SIGNED_MULDIV_EN
      run_op("mult -3x5", F_MULT, 32'hFFFF_FFFD, 32'd5,
             1'b0, F_MULT, 1'b0, 33);
      check("mult lo", 64'(Lo), 64'hFFFF_FFF1);
      step();
      run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2,
             1'b0, F_DIV, 1'b0, 33);
      check("div hi", 64'(Hi), 64'hFFFF_FFFF);
      step();
`else
      ALUOp = 3'b111;
      ALUFunction = F_MULT;
      ReadData1 = 32'hFFFF_FFFD;
      ReadData2 = 32'd5;
      start = 1'b1;
      #1;
      check("mult op", 64'(ALUOperation), 64'h9);
      check("mult stall", 64'(Stall), 64'd0);
      step();
      check("mult no run", 64'(Stall), 64'd0);
      check("mult no done", 64'(Done), 64'd0);
      start = 1'b0;
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
